// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
package div_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [DEF_WIDTH-1:0] QUOT_DBZ = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;

    // The running remainder is always below the divisor, so the subtraction
    // result fits in WIDTH bits and can be taken modulo 2^WIDTH.
    always_comb begin
        shifted = {rem_i, bit_i};
        qbit_o  = (shifted >= {1'b0, divisor_i});
        rem_o   = qbit_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_8x8.sv
// Iterative unsigned divider: one quotient bit per cycle, divide-by-zero flagged in one cycle.
module div_8x8
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] QUOT_ALL = {WIDTH{QUOT_DBZ[0]}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (prem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Quotient bits fill the dividend register from the bottom as its bits shift out.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    dvd_d  = in_1;
                    dvs_d  = in_2;
                    prem_d = '0;
                    cnt_d  = CW'(WIDTH - 1);
                    if (in_2 == '0) begin
                        state_d = DONE;
                        quot_d  = QUOT_ALL;
                        rem_d   = in_1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dvd_d  = {dvd_q[WIDTH-2:0], step_qbit};
                prem_d = step_rem;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quot_d  = {dvd_q[WIDTH-2:0], step_qbit};
                    rem_d   = step_rem;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_8x8.sv
// Randomised and directed checks of div_8x8 against an arithmetic reference model.
module tb_div_8x8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in_1, in_2;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quot, rem;

    int n_assert = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    int           m_busy_cnt;
    logic         m_done, m_dbz;
    logic [W-1:0] m_quot, m_rem, p_q, p_r;

    always #5 clk = ~clk;

    div_8x8 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_1        (in_1),
        .in_2        (in_2),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    // Reference: a request takes W busy cycles then one done cycle; results from / and %.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy_cnt = 0;
            m_done     = 1'b0;
            m_dbz      = 1'b0;
            m_quot     = '0;
            m_rem      = '0;
        end else if (m_busy_cnt > 0) begin
            m_busy_cnt = m_busy_cnt - 1;
            m_done     = (m_busy_cnt == 0);
            if (m_done) begin
                m_quot = p_q;
                m_rem  = p_r;
                m_dbz  = 1'b0;
            end
        end else if (start) begin
            if (in_2 == 0) begin
                m_done = 1'b1;
                m_quot = '1;
                m_rem  = in_1;
                m_dbz  = 1'b1;
            end else begin
                m_done     = 1'b0;
                m_busy_cnt = W;
                p_q        = in_1 / in_2;
                p_r        = in_1 % in_2;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            n_assert++;
            if (busy !== (m_busy_cnt > 0) || done !== m_done || quot !== m_quot ||
                rem !== m_rem || div_by_zero !== m_dbz) begin
                n_fail++;
                $display("FAIL cycle-compare t=%0t: got busy=%b done=%b quot=%0d rem=%0d dbz=%b, expected busy=%b done=%b quot=%0d rem=%0d dbz=%b",
                         $time, busy, done, quot, rem, div_by_zero,
                         (m_busy_cnt > 0), m_done, m_quot, m_rem, m_dbz);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Waits for done from the negedge right after the accepting edge.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        int lat, bc;
        @(negedge clk);
        start = 1'b1;
        in_1  = a;
        in_2  = b;
        @(negedge clk);
        start = 1'b0;
        in_1  = 8'($urandom);
        in_2  = 8'($urandom);
        wait_done(lat, bc);
        check($sformatf("latency %0d/%0d", a, b), lat, (b == 0) ? 0 : W);
        check($sformatf("busy cycles %0d/%0d", a, b), bc, (b == 0) ? 0 : W);
        check($sformatf("quot %0d/%0d", a, b), quot, eq);
        check($sformatf("rem %0d/%0d", a, b), rem, er);
        check($sformatf("dbz %0d/%0d", a, b), div_by_zero, edbz);
    endtask

    initial begin
        int lat, bc, extra, rdone;
        rst   = 1'b1;
        start = 1'b0;
        in_1  = '0;
        in_2  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quot", quot, 0);
        check("reset rem", rem, 0);
        check("reset dbz", div_by_zero, 0);
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        run_op(8'd20, 8'd4, 8'd5, 8'd0, 1'b0);
        run_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        run_op(8'd3, 8'd6, 8'd0, 8'd3, 1'b0);
        run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        run_op(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
        run_op(8'd56, 8'd24, 8'd2, 8'd8, 1'b0);

        // start during busy must be ignored
        @(negedge clk);
        start = 1'b1; in_1 = 8'd24; in_2 = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; in_1 = 8'd100; in_2 = 8'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("busy-ignore quot", quot, 4);
        check("busy-ignore rem", rem, 4);
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("busy-ignore extra dones", extra, 0);

        // start held through DONE: second request accepted back-to-back
        @(negedge clk);
        start = 1'b1; in_1 = 8'd20; in_2 = 8'd3;
        @(negedge clk);
        wait_done(lat, bc);
        check("b2b first lat", lat, W);
        check("b2b first quot", quot, 6);
        check("b2b first rem", rem, 2);
        in_1 = 8'd50; in_2 = 8'd7;
        @(negedge clk);
        start = 1'b0;
        in_1 = 8'($urandom); in_2 = 8'($urandom);
        check("b2b second accepted", busy, 1);
        wait_done(lat, bc);
        check("b2b second lat", lat, W);
        check("b2b second quot", quot, 7);
        check("b2b second rem", rem, 1);

        // reset mid-division aborts without a done pulse
        @(negedge clk);
        start = 1'b1; in_1 = 8'd200; in_2 = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort quot", quot, 0);
        check("abort rem", rem, 0);
        check("abort dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("abort no done", extra, 0);
        run_op(8'd36, 8'd6, 8'd6, 8'd0, 1'b0);

        // random traffic, including starts while busy and zero divisors
        rdone = 0;
        repeat (2000) begin
            @(negedge clk);
            if (done === 1'b1) rdone++;
            start = ($urandom_range(0, 2) == 0);
            in_1  = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       in_2 = '0;
                1, 2, 3: in_2 = 8'($urandom_range(1, 15));
                default: in_2 = 8'($urandom);
            endcase
        end
        start = 1'b0;
        check("random dones seen", (rdone > 50), 1);
        repeat (12) @(negedge clk);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
